// File: rtl/mode_counter_pkg.sv
// mode_counter_pkg
// Shared definitions for the multi-mode counter: the counting-mode enum,
// the raw 2-bit mode encodings and a decode helper that maps the raw
// `mode` pin value onto the enum.
package mode_counter_pkg;

    typedef enum logic [1:0] {
        MODE_UP       = 2'b00,
        MODE_DOWN     = 2'b01,
        MODE_PINGPONG = 2'b10,
        MODE_ONESHOT  = 2'b11
    } mode_e;

    localparam logic [1:0] MODE_UP_ENC       = 2'b00;
    localparam logic [1:0] MODE_DOWN_ENC     = 2'b01;
    localparam logic [1:0] MODE_PINGPONG_ENC = 2'b10;
    localparam logic [1:0] MODE_ONESHOT_ENC  = 2'b11;

    // Map the raw pin encoding onto the enum. The default arm guards
    // against X/unknown values by falling back to plain up-counting.
    function automatic mode_e decode_mode(input logic [1:0] raw);
        mode_e m;
        case (raw)
            MODE_UP_ENC:       m = MODE_UP;
            MODE_DOWN_ENC:     m = MODE_DOWN;
            MODE_PINGPONG_ENC: m = MODE_PINGPONG;
            MODE_ONESHOT_ENC:  m = MODE_ONESHOT;
            default:           m = MODE_UP;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mode_counter_tick.sv
// tick_prescaler
// Divides the count enable so that `tick` pulses once every `div`+1
// enabled cycles. The divider advances only while `en` is high and
// holds otherwise; `clr` (driven by the counter load) restarts it.
// Only built when MODE_COUNTER_PRESCALE_EN is defined.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   en    - count enable
//   clr   - synchronous clear of the divider
//   div   - divisor minus one
//   tick  - step enable for the counter (combinational from divider state)
`ifdef MODE_COUNTER_PRESCALE_EN
module tick_prescaler #(
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] div,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] div_cnt_r;
    logic                  wrap_s;

    // Divider wraps when it has reached the programmed divisor.
    always_comb begin
        wrap_s = (div_cnt_r == div);
    end

    // Tick is issued during the last enabled cycle of each divider period,
    // so the counter steps on the edge that closes that period.
    always_comb begin
        if (clr) begin
            tick = 1'b0;
        end else begin
            tick = en & wrap_s;
        end
    end

    // Divider state: cleared by load, advanced on enabled cycles only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_r <= {PRESCALE_W{1'b0}};
        end else if (clr) begin
            div_cnt_r <= {PRESCALE_W{1'b0}};
        end else if (en) begin
            if (wrap_s) begin
                div_cnt_r <= {PRESCALE_W{1'b0}};
            end else begin
                div_cnt_r <= div_cnt_r + {{(PRESCALE_W-1){1'b0}}, 1'b1};
            end
        end else begin
            div_cnt_r <= div_cnt_r;
        end
    end

endmodule
`endif

// File: rtl/mode_counter.sv
// mode_counter
// Parametrised multi-mode counter: up, down, ping-pong and one-shot
// counting with synchronous load, registered terminal-count and
// compare-match pulses.
// Build option: define MODE_COUNTER_PRESCALE_EN to place a tick_prescaler
// in front of the step enable; otherwise every enabled cycle is a step
// and `prescale_div` is ignored. The port list is the same either way.
// Ports:
//   clk          - clock, rising edge
//   rst_n        - asynchronous active-low reset
//   en           - count enable
//   mode         - 00 up, 01 down, 10 ping-pong, 11 one-shot
//   load         - synchronous load strobe (beats stepping)
//   load_val     - value taken on load
//   cmp_val      - compare value
//   prescale_div - tick every prescale_div+1 enabled cycles (prescaler build)
//   count        - registered count
//   dir_up       - current counting direction
//   tc_pulse     - registered terminal-count pulse
//   cmp_match    - registered compare-match pulse
//   done         - one-shot has reached the maximum
module mode_counter
    import mode_counter_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic [WIDTH-1:0]      cmp_val,
    input  logic [PRESCALE_W-1:0] prescale_div,
    output logic [WIDTH-1:0]      count,
    output logic                  dir_up,
    output logic                  tc_pulse,
    output logic                  cmp_match,
    output logic                  done
);

    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MAX_C  = {WIDTH{1'b1}};

    mode_e            mode_s;
    logic             tick_s;
    logic [WIDTH-1:0] count_r;
    logic             dir_r;
    logic             tc_r;
    logic             cmp_r;
    logic [WIDTH-1:0] next_count_s;
    logic             next_dir_s;
    logic             next_tc_s;
    logic             next_cmp_s;
    logic             stepped_s;
    logic [WIDTH-1:0] step_count_s;

`ifdef MODE_COUNTER_PRESCALE_EN
    tick_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_tick_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clr   (load),
        .div   (prescale_div),
        .tick  (tick_s)
    );
`else
    logic unused_prescale_s;

    // Without the prescaler every enabled cycle is a step.
    always_comb begin
        tick_s            = en;
        unused_prescale_s = ^prescale_div;
    end
`endif

    // Decode the raw mode pins.
    always_comb begin
        mode_s = decode_mode(mode);
    end

    // Next-state: load beats tick beats hold. Pulses only come from a
    // real step, so loads and ignored one-shot ticks never raise them.
    always_comb begin
        next_count_s = count_r;
        next_dir_s   = dir_r;
        next_tc_s    = 1'b0;
        next_cmp_s   = 1'b0;
        stepped_s    = 1'b0;
        step_count_s = count_r;
        if (load) begin
            next_count_s = load_val;
            next_dir_s   = 1'b1;
        end else if (tick_s) begin
            case (mode_s)
                MODE_UP: begin
                    stepped_s    = 1'b1;
                    step_count_s = count_r + ONE_C;
                    next_tc_s    = (count_r == MAX_C);
                end
                MODE_DOWN: begin
                    stepped_s    = 1'b1;
                    step_count_s = count_r - ONE_C;
                    next_tc_s    = (count_r == ZERO_C);
                end
                MODE_PINGPONG: begin
                    stepped_s = 1'b1;
                    // Turnaround steps back inward and flips direction
                    // on the same edge.
                    if (dir_r) begin
                        if (count_r == MAX_C) begin
                            step_count_s = MAX_C - ONE_C;
                            next_dir_s   = 1'b0;
                            next_tc_s    = 1'b1;
                        end else begin
                            step_count_s = count_r + ONE_C;
                        end
                    end else begin
                        if (count_r == ZERO_C) begin
                            step_count_s = ONE_C;
                            next_dir_s   = 1'b1;
                            next_tc_s    = 1'b1;
                        end else begin
                            step_count_s = count_r - ONE_C;
                        end
                    end
                end
                MODE_ONESHOT: begin
                    // Parked at MAX: the tick is swallowed.
                    if (count_r != MAX_C) begin
                        stepped_s    = 1'b1;
                        step_count_s = count_r + ONE_C;
                        next_tc_s    = (count_r == (MAX_C - ONE_C));
                    end else begin
                        stepped_s    = 1'b0;
                    end
                end
                default: begin
                    stepped_s    = 1'b0;
                end
            endcase
            next_count_s = step_count_s;
            next_cmp_s   = stepped_s & (step_count_s == cmp_val);
        end else begin
            next_count_s = count_r;
        end
    end

    // State and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= ZERO_C;
            dir_r   <= 1'b1;
            tc_r    <= 1'b0;
            cmp_r   <= 1'b0;
        end else begin
            count_r <= next_count_s;
            dir_r   <= next_dir_s;
            tc_r    <= next_tc_s;
            cmp_r   <= next_cmp_s;
        end
    end

    // Outputs: direction is fixed by mode except in ping-pong, where the
    // retained direction register is shown.
    always_comb begin
        case (mode_s)
            MODE_UP:       dir_up = 1'b1;
            MODE_DOWN:     dir_up = 1'b0;
            MODE_PINGPONG: dir_up = dir_r;
            MODE_ONESHOT:  dir_up = 1'b1;
            default:       dir_up = 1'b1;
        endcase
        count     = count_r;
        tc_pulse  = tc_r;
        cmp_match = cmp_r;
        done      = (mode_s == MODE_ONESHOT) && (count_r == MAX_C);
    end

endmodule
